// File: rtl/leaky_relu_pipe_pkg.sv
// Shared FP32 field constants, mode encodings and per-lane S1 state for leaky_relu_pipe.
// Classification helpers treat subnormals as zero (flush-to-zero datapath).
package leaky_relu_pipe_pkg;

    localparam int unsigned FpSignBit = 31;
    localparam int unsigned FpExpW    = 8;
    localparam int unsigned FpManW    = 23;
    localparam int unsigned FpBias    = 127;

    localparam logic [FpExpW-1:0] FpExpMax   = 8'hFF;
    localparam logic [31:0]       FpCanonNan = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ModeIdentity  = 2'b00,
        ModeRelu      = 2'b01,
        ModeLeaky     = 2'b10,
        ModeIdentityB = 2'b11
    } lrelu_mode_e;

    // Everything S2 needs to finish one lane: either a fully decided result
    // (bypass) or the sign, biased exponent sum and raw mantissa product.
    typedef struct packed {
        logic        bypass;
        logic [31:0] bypass_val;
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] prod;
    } lane_s1_t;

    function automatic logic fp_is_nan(input logic [31:0] v);
        return (v[30:23] == FpExpMax) && (v[22:0] != '0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] v);
        return (v[30:23] == FpExpMax) && (v[22:0] == '0);
    endfunction

    function automatic logic fp_is_zero(input logic [31:0] v);
        return v[30:23] == '0;
    endfunction

endpackage

// File: rtl/lrelu_fp32_mul.sv
// One lane of the leaky-ReLU pipe: sign/exponent/special-case decode and mantissa
// product in S1, normalise, round-to-nearest-even and range clamp in S2.
module lrelu_fp32_mul
    import leaky_relu_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        s1_en,
    input  logic        s2_en,
    input  lrelu_mode_e mode,
    input  logic [31:0] x,
    input  logic [31:0] alpha,
    output logic [31:0] y
);

    lane_s1_t    s1_d, s1_q;
    logic [31:0] y_d, y_q;

    logic        x_nan, x_inf, x_zero;
    logic        a_nan, a_inf, a_zero;
    logic        p_sign;
    logic [47:0] x_man, a_man;

    always_comb begin
        x_nan  = fp_is_nan(x);
        x_inf  = fp_is_inf(x);
        x_zero = fp_is_zero(x);
        a_nan  = fp_is_nan(alpha);
        a_inf  = fp_is_inf(alpha);
        a_zero = fp_is_zero(alpha);
        p_sign = x[FpSignBit] ^ alpha[FpSignBit];
        x_man  = {24'd0, 1'b1, x[FpManW-1:0]};
        a_man  = {24'd0, 1'b1, alpha[FpManW-1:0]};

        s1_d            = '0;
        s1_d.bypass     = 1'b1;
        s1_d.bypass_val = x;
        s1_d.sign       = p_sign;
        s1_d.exp        = {2'b00, x[30:23]} + {2'b00, alpha[30:23]} - 10'(FpBias);
        s1_d.prod       = x_man * a_man;

        // Non-negative inputs always pass unchanged, so only the sign-set case decodes mode.
        if (x[FpSignBit]) begin
            case (mode)
                ModeRelu: s1_d.bypass_val = '0;
                ModeLeaky: begin
                    if (x_nan) begin
                        s1_d.bypass_val = x;
                    end else if (a_nan) begin
                        s1_d.bypass_val = alpha;
                    end else if ((x_inf && a_zero) || (x_zero && a_inf)) begin
                        s1_d.bypass_val = FpCanonNan;
                    end else if (x_inf || a_inf) begin
                        s1_d.bypass_val = {p_sign, FpExpMax, 23'd0};
                    end else if (x_zero || a_zero) begin
                        s1_d.bypass_val = {p_sign, 31'd0};
                    end else begin
                        s1_d.bypass = 1'b0;
                    end
                end
                default: s1_d.bypass_val = x;
            endcase
        end
    end

    logic [22:0]       man;
    logic              guard, sticky, round_up;
    logic [23:0]       man_rnd;
    logic signed [9:0] e_norm, e_rnd;

    always_comb begin
        if (s1_q.prod[47]) begin
            man    = s1_q.prod[46:24];
            guard  = s1_q.prod[23];
            sticky = |s1_q.prod[22:0];
            e_norm = $signed(s1_q.exp) + 10'sd1;
        end else begin
            man    = s1_q.prod[45:23];
            guard  = s1_q.prod[22];
            sticky = |s1_q.prod[21:0];
            e_norm = $signed(s1_q.exp);
        end
        round_up = guard && (sticky || man[0]);
        man_rnd  = {1'b0, man} + {23'd0, round_up};
        // Rounding carry out of the mantissa bumps the exponent; the fraction is then zero.
        e_rnd    = man_rnd[23] ? e_norm + 10'sd1 : e_norm;

        if (s1_q.bypass) begin
            y_d = s1_q.bypass_val;
        end else if (e_rnd >= 10'sd255) begin
            y_d = {s1_q.sign, FpExpMax, 23'd0};
        end else if (e_rnd <= 10'sd0) begin
            y_d = {s1_q.sign, 31'd0};
        end else begin
            y_d = {s1_q.sign, e_rnd[7:0], man_rnd[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            y_q  <= '0;
        end else begin
            if (s1_en) begin
                s1_q <= s1_d;
            end
            if (s2_en) begin
                y_q <= y_d;
            end
        end
    end

    assign y = y_q;

endmodule

// File: rtl/leaky_relu_pipe.sv
// Two-stage, LANES-wide FP32 identity / ReLU / leaky-ReLU pipe with valid/ready handshake.
// Define LRELU_NEG_COUNT_EN to add the neg_count output (negative-lane counter).
module leaky_relu_pipe
    import leaky_relu_pipe_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [31:0]         alpha,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*LANES-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag
`ifdef LRELU_NEG_COUNT_EN
    ,
    output logic [31:0]         neg_count
`endif
);

    logic             v1_q, v1_d, v2_q, v2_d;
    logic             s1_load, s2_load, in_fire, s2_fire;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    lrelu_mode_e      mode_sel;

    assign mode_sel = lrelu_mode_e'(mode);

    // Each stage advances when it is empty or its successor advances.
    always_comb begin
        s2_load  = !v2_q || out_ready;
        s1_load  = !v1_q || s2_load;
        in_ready = s1_load;
        in_fire  = in_valid && in_ready;
        s2_fire  = s2_load && v1_q;
        v1_d     = s1_load ? in_valid : v1_q;
        v2_d     = s2_load ? v1_q : v2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (in_fire) begin
                tag1_q <= in_tag;
            end
            if (s2_fire) begin
                tag2_q <= tag1_q;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lrelu_fp32_mul u_mul (
            .clk   (clk),
            .rst   (rst),
            .s1_en (in_fire),
            .s2_en (s2_fire),
            .mode  (mode_sel),
            .x     (in_data[32*i +: 32]),
            .alpha (alpha),
            .y     (out_data[32*i +: 32])
        );
    end

    assign out_valid = v2_q;
    assign out_tag   = tag2_q;

`ifdef LRELU_NEG_COUNT_EN
    logic [LANES-1:0] in_neg, neg1_q, neg2_q;
    logic [31:0]      neg_sum, neg_count_d, neg_count_q;

    always_comb begin
        in_neg  = '0;
        neg_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            in_neg[i] = in_data[32*i+FpSignBit];
            neg_sum   = neg_sum + {31'd0, neg2_q[i]};
        end
        neg_count_d = neg_count_q + ((v2_q && out_ready) ? neg_sum : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg1_q      <= '0;
            neg2_q      <= '0;
            neg_count_q <= '0;
        end else begin
            if (in_fire) begin
                neg1_q <= in_neg;
            end
            if (s2_fire) begin
                neg2_q <= neg1_q;
            end
            neg_count_q <= neg_count_d;
        end
    end

    assign neg_count = neg_count_q;
`endif

endmodule

// File: tb/tb_leaky_relu_pipe.sv
// Directed self-checking bench for leaky_relu_pipe (LANES=4, TAG_W=8).
module tb_leaky_relu_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 8;
    localparam logic [31:0] A_TENTH = 32'h3DCC_CCCD;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          mode = 2'b00;
    logic [31:0]         alpha = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [32*LANES-1:0] in_data = '0;
    logic [TAG_W-1:0]    in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [32*LANES-1:0] out_data;
    logic [TAG_W-1:0]    out_tag;
`ifdef LRELU_NEG_COUNT_EN
    logic [31:0]         neg_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    leaky_relu_pipe #(
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .alpha     (alpha),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef LRELU_NEG_COUNT_EN
        ,
        .neg_count (neg_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single beat with out_ready=1: invisible after one cycle, visible after exactly two.
    task automatic run_one(input string name, input logic [1:0] m, input logic [31:0] a,
                           input logic [127:0] d, input logic [7:0] t, input logic [127:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        mode      = m;
        alpha     = a;
        in_data   = d;
        in_tag    = t;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = ~m;
        alpha     = 32'h3F80_0000;
        check_eq({name, "_early"}, {127'd0, out_valid}, 128'd0);
        @(negedge clk);
        check_eq({name, "_valid"}, {127'd0, out_valid}, 128'd1);
        check_eq({name, "_data"}, out_data, exp);
        check_eq({name, "_tag"}, {120'd0, out_tag}, {120'd0, t});
    endtask

    function automatic logic [127:0] beat_data(input int i);
        return {32'h8000_0000, 32'hBF80_0000, 32'h4040_0000 + 32'(i), 32'hC000_0000};
    endfunction

    function automatic logic [127:0] beat_exp(input int i);
        if (i % 2 == 0) return {32'h8000_0000, 32'hBDCC_CCCD, 32'h4040_0000 + 32'(i), 32'hBE4C_CCCD};
        return {32'h0, 32'h0, 32'h4040_0000 + 32'(i), 32'h0};
    endfunction

    // Ten beats, even tags leaky and odd tags ReLU; stall=1 toggles out_ready 1,0,0,...
    task automatic run_stream(input bit stall, output int iters);
        int tx = 0;
        int rx = 0;
        bit pstall = 1'b0;
        logic [127:0] pd = '0;
        logic [7:0]   pt = '0;
        iters = 0;
        for (int c = 0; c < 300 && rx < 10; c++) begin
            @(negedge clk);
            out_ready = stall ? (c % 3 == 0) : 1'b1;
            in_valid  = (tx < 10);
            in_tag    = 8'(tx);
            mode      = (tx % 2 == 0) ? 2'b10 : 2'b01;
            alpha     = A_TENTH;
            in_data   = beat_data(tx);
            #1;
            if (pstall) begin
                check_eq("stall_valid", {127'd0, out_valid}, 128'd1);
                check_eq("stall_data", out_data, pd);
                check_eq("stall_tag", {120'd0, out_tag}, {120'd0, pt});
            end
            if (out_valid && out_ready) begin
                check_eq("strm_data", out_data, beat_exp(rx));
                check_eq("strm_tag", {120'd0, out_tag}, 128'(rx));
                rx++;
            end
            pstall = out_valid && !out_ready;
            pd     = out_data;
            pt     = out_tag;
            if (in_valid && in_ready) tx++;
            iters = c + 1;
        end
        check_eq("strm_count", 128'(rx), 128'd10);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("strm_drained", {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        int iters;

        #1;
        check_eq("rst_valid", {127'd0, out_valid}, 128'd0);
        check_eq("rst_ready", {127'd0, in_ready}, 128'd1);
        check_eq("rst_data", out_data, 128'd0);
        check_eq("rst_tag", {120'd0, out_tag}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one("leaky_a", 2'b10, A_TENTH,
                {32'h7FC0_0000, 32'h8000_0000, 32'h4040_0000, 32'hC000_0000}, 8'h11,
                {32'h7FC0_0000, 32'h8000_0000, 32'h4040_0000, 32'hBE4C_CCCD});
        run_one("relu", 2'b01, A_TENTH,
                {32'hFF80_0000, 32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000}, 8'h22,
                {32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000});
        run_one("leaky_sp", 2'b10, A_TENTH,
                {32'hC040_0000, 32'h8000_0001, 32'hFFC0_0001, 32'hFF80_0000}, 8'h33,
                {32'hBE99_999A, 32'h8000_0000, 32'hFFC0_0001, 32'hFF80_0000});
        run_one("ident0", 2'b00, A_TENTH,
                {32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000}, 8'h44,
                {32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000});
        run_one("ident3", 2'b11, A_TENTH,
                {32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000}, 8'h55,
                {32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000});
        run_one("alpha0", 2'b10, 32'h0000_0000,
                {32'hFFC0_0001, 32'h3F80_0000, 32'hBF80_0000, 32'hFF80_0000}, 8'h66,
                {32'hFFC0_0001, 32'h3F80_0000, 32'h8000_0000, 32'h7FC0_0000});
        run_one("ovf", 2'b10, 32'h7F00_0000,
                {32'h0000_0001, 32'hC000_0000, 32'hBF80_0000, 32'hFF00_0000}, 8'h77,
                {32'h0000_0001, 32'hFF80_0000, 32'hFF00_0000, 32'hFF80_0000});
        run_one("unf", 2'b10, A_TENTH,
                {32'h7F80_0000, 32'hBF80_0000, 32'hC040_0000, 32'h8080_0000}, 8'h88,
                {32'h7F80_0000, 32'hBDCC_CCCD, 32'hBE99_999A, 32'h8000_0000});

        run_stream(1'b1, iters);

        // Fill both stages under backpressure, then reset.
        @(negedge clk);
        out_ready = 1'b0;
        mode      = 2'b10;
        alpha     = A_TENTH;
        in_valid  = 1'b1;
        in_data   = beat_data(0);
        in_tag    = 8'hA0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check_eq("full_valid", {127'd0, out_valid}, 128'd1);
        check_eq("full_ready", {127'd0, in_ready}, 128'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        check_eq("mid_rst_ready", {127'd0, in_ready}, 128'd1);
        check_eq("mid_rst_data", out_data, 128'd0);
        check_eq("mid_rst_tag", {120'd0, out_tag}, 128'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("no_stale", {127'd0, out_valid}, 128'd0);
        end
`ifdef LRELU_NEG_COUNT_EN
        check_eq("negcnt_rst", 128'(neg_count), 128'd0);
`endif
        run_one("post_rst", 2'b10, A_TENTH,
                {32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'hC000_0000}, 8'h5A,
                {32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000, 32'hBE4C_CCCD});

        run_stream(1'b0, iters);
        check_eq("full_rate_iters", 128'(iters), 128'd12);
`ifdef LRELU_NEG_COUNT_EN
        check_eq("negcnt_total", 128'(neg_count), 128'd31);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
